// File: rtl/ms_es_mul_sched_pkg.sv
// Shared types and defaults for the multiplier job scheduler.
package ms_es_sched_pkg;

    localparam int DEF_DATA_WIDTH = 5;
    localparam int DEF_NUM_INPUTS = 2;

    typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} sched_state_t;

    typedef logic [DEF_DATA_WIDTH-1:0] operand_t;

    // Exhaustive worst case of the by-2 multiplier plus a small margin.
    function automatic int default_timeout(input int dw, input int ni);
        return (1 << (dw * ni)) + 8;
    endfunction

endpackage

// File: rtl/ms_es_mul_sched_if.sv
// Requester-side job port and result port of the multiplier scheduler.
interface ms_es_mul_sched_if #(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2,
    parameter int NUM_REQ    = 4
) ();
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int PROD_W = NUM_INPUTS * DATA_WIDTH;

    // A transfer happens on a rising clk edge where valid and ready are both 1;
    // a source keeps its payload stable while valid is high and ready is low.
    logic [NUM_REQ-1:0]                       req_valid;
    logic [NUM_REQ*NUM_INPUTS*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                       req_ready;
    logic                                     rsp_valid;
    logic                                     rsp_ready;
    logic [ID_W-1:0]                          rsp_id;
    logic [PROD_W-1:0]                        rsp_data;
    logic                                     rsp_err;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/ms_es_mul_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);
    logic [PW-1:0] idx;

    // Scan from farthest to nearest so the closest requester overwrites the rest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        if (en) begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = PW'((int'(ptr) + k) % N);
                if (req[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    grant_idx  = idx;
                end
            end
        end
    end
endmodule

// File: rtl/ms_es_mul_sched.sv
// Shares one by-2 multiplier among NUM_REQ requesters: round-robin grant,
// clear, run under a watchdog, then return the tagged product.
module ms_es_mul_sched
    import ms_es_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = default_timeout(DATA_WIDTH, NUM_INPUTS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    ms_es_mul_sched_if.slave                     bus,
    output logic                                 mul_clr,
    output logic                                 mul_en,
    output logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] mul_data_in,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]     mul_data_out,
    input  logic                                 mul_done,
    output sched_state_t                         dbg_state
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int PROD_W = NUM_INPUTS * DATA_WIDTH;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    sched_state_t      state, state_nxt;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   rsp_id_q;
    logic [PROD_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic              req_hs;
    logic              timeout;

    // Gating with rst keeps req_ready low while reset is asserted.
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .en        (state == IDLE && rst),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_hs  = |grant;
    assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_hs) state_nxt = CLR;
            CLR:     state_nxt = RUN;
            RUN:     if (mul_done || timeout) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mul_clr       = 1'b0;
        mul_en        = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.req_ready = grant;
        dbg_state     = state;
        case (state)
            CLR:     mul_clr = 1'b1;
            RUN:     mul_en = 1'b1;
            RESP:    bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Job datapath and watchdog; done takes priority over an expiring counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_data_in <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rr_ptr      <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: if (req_hs) begin
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        mul_data_in[i] <= bus.req_data[(int'(grant_idx) * NUM_INPUTS + i) * DATA_WIDTH +: DATA_WIDTH];
                    end
                    rsp_id_q <= grant_idx;
                    rr_ptr   <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                end
                CLR: cnt <= '0;
                RUN: begin
                    if (cnt != CNT_W'(TIMEOUT)) cnt <= cnt + CNT_W'(1);
                    if (mul_done) begin
                        rsp_data_q <= mul_data_out;
                        rsp_err_q  <= 1'b0;
                    end else if (timeout) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_id   = rsp_id_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_err  = rsp_err_q;
endmodule

// File: tb/tb_ms_es_mul_sched.sv
// Bench for ms_es_mul_sched with a behavioural multiplier stub and a job-level reference model.
module tb_ms_es_mul_sched;
    import ms_es_sched_pkg::*;

    localparam int DW      = 5;
    localparam int NI      = 2;
    localparam int NR      = 4;
    localparam int PW      = NI * DW;
    localparam int IW      = 2;
    localparam int TIMEOUT = default_timeout(DW, NI);
    localparam int RLW     = 12;
    localparam int EW      = IW + PW + 1 + RLW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ms_es_mul_sched_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_REQ(NR)) bus ();

    logic                   mul_clr, mul_en, mul_done;
    logic [NI-1:0][DW-1:0]  mul_data_in;
    logic [PW-1:0]          mul_data_out;
    sched_state_t           dbg_state;

    ms_es_mul_sched #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_REQ(NR)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mul_clr      (mul_clr),
        .mul_en       (mul_en),
        .mul_data_in  (mul_data_in),
        .mul_data_out (mul_data_out),
        .mul_done     (mul_done),
        .dbg_state    (dbg_state)
    );

    operand_t ops [NR][NI];
    always_comb begin
        bus.req_data = '0;
        for (int r = 0; r < NR; r++)
            for (int i = 0; i < NI; i++)
                bus.req_data[(r * NI + i) * DW +: DW] = ops[r][i];
    end

    // Multiplier stub: done after tgt+1 enabled cycles since the last clear.
    int   en_cnt = 0;
    int   tgt    = 0;
    logic spur   = 1'b0;
    always @(posedge clk) begin
        if (mul_clr)     en_cnt <= 0;
        else if (mul_en) en_cnt <= en_cnt + 1;
    end
    assign mul_done     = (mul_en && en_cnt == tgt) || spur;
    assign mul_data_out = PW'(mul_data_in[0]) * PW'(mul_data_in[1]);

    // ---------------- reference model / scoreboard ----------------
    int                n_chk = 0;
    int                n_pass = 0;
    int                model_ptr = 0;
    bit                busy = 1'b0;
    logic [EW-1:0]     exp_q[$];
    int                gnt_log[$];
    logic [PW-1:0]     last_rsp_data;

    function automatic int model_winner(input logic [NR-1:0] v);
        for (int k = 0; k < NR; k++)
            if (v[(model_ptr + k) % NR]) return (model_ptr + k) % NR;
        return -1;
    endfunction

    function automatic logic [EW-1:0] model_rsp(input int id, input int t);
        int prod;
        prod = int'(ops[id][0]) * int'(ops[id][1]);
        if (t > TIMEOUT - 1) return {IW'(id), PW'(0), 1'b1, RLW'(TIMEOUT)};
        return {IW'(id), PW'(prod), 1'b0, RLW'(t + 1)};
    endfunction

    task automatic randomize_ops();
        for (int r = 0; r < NR; r++)
            for (int i = 0; i < NI; i++)
                ops[r][i] = operand_t'($urandom_range(0, 31));
    endtask

    // ---------------- driver: generic job stream ----------------
    task automatic serve(input logic [NR-1:0] mask, input int n_jobs, input bit rand_ready,
                         input int tgt_lo, input int tgt_hi, input bit rand_data);
        int grants = 0;
        int dones = 0;
        int last = -1;
        int budget;
        int w;
        int dut_w;
        logic [NR-1:0] exp_rdy;
        logic [EW-1:0] e;
        budget = n_jobs * (TIMEOUT + 40);
        if (rand_data) randomize_ops();
        bus.req_valid = mask;
        while (dones < n_jobs && budget > 0) begin
            budget--;
            bus.rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            w = model_winner(bus.req_valid);
            exp_rdy = (busy || w < 0) ? '0 : (NR'(1) << w);
            n_chk++;
            if (bus.req_ready !== exp_rdy) $display("FAIL req_ready: got %b want %b", bus.req_ready, exp_rdy);
            else n_pass++;
            if (|bus.req_ready) begin
                dut_w = -1;
                for (int i = 0; i < NR; i++) if (bus.req_ready[i]) dut_w = i;
                gnt_log.push_back(dut_w);
            end
            if (!busy && w >= 0) begin
                tgt = $urandom_range(tgt_lo, tgt_hi);
                exp_q.push_back(model_rsp(w, tgt));
                model_ptr = (w + 1) % NR;
                busy = 1'b1;
                grants++;
                last = w;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_rsp: got id %0d with empty queue want none", bus.rsp_id);
                end else begin
                    n_pass++;
                    e = exp_q.pop_front();
                    n_chk++;
                    if (bus.rsp_id !== e[EW-1 -: IW]) $display("FAIL rsp_id: got %0d want %0d", bus.rsp_id, e[EW-1 -: IW]);
                    else n_pass++;
                    n_chk++;
                    if (bus.rsp_data !== e[EW-IW-1 -: PW]) $display("FAIL rsp_data: got %0d want %0d", bus.rsp_data, e[EW-IW-1 -: PW]);
                    else n_pass++;
                    n_chk++;
                    if (bus.rsp_err !== e[RLW]) $display("FAIL rsp_err: got %b want %b", bus.rsp_err, e[RLW]);
                    else n_pass++;
                    n_chk++;
                    if (en_cnt != int'(e[RLW-1:0])) $display("FAIL run_cycles: got %0d want %0d", en_cnt, int'(e[RLW-1:0]));
                    else n_pass++;
                    last_rsp_data = bus.rsp_data;
                end
                busy = 1'b0;
                dones++;
            end
            @(negedge clk);
            if (last >= 0) begin
                if (grants >= n_jobs) bus.req_valid = '0;
                else if (rand_data) for (int i = 0; i < NI; i++) ops[last][i] = operand_t'($urandom_range(0, 31));
                last = -1;
            end
        end
        n_chk++;
        if (dones < n_jobs) $display("FAIL serve_budget: got %0d responses want %0d", dones, n_jobs);
        else n_pass++;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        randomize_ops();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_chk++; if (bus.req_ready !== '0) $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); else n_pass++;
        n_chk++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
        n_chk++; if (bus.rsp_id !== '0) $display("FAIL rst_rsp_id: got %0d want 0", bus.rsp_id); else n_pass++;
        n_chk++; if (bus.rsp_data !== '0) $display("FAIL rst_rsp_data: got %0d want 0", bus.rsp_data); else n_pass++;
        n_chk++; if (bus.rsp_err !== 1'b0) $display("FAIL rst_rsp_err: got %b want 0", bus.rsp_err); else n_pass++;
        n_chk++; if (mul_clr !== 1'b0 || mul_en !== 1'b0) $display("FAIL rst_mul_ctl: got clr %b en %b want 0 0", mul_clr, mul_en); else n_pass++;
        n_chk++; if (mul_data_in !== '0) $display("FAIL rst_mul_data_in: got %h want 0", mul_data_in); else n_pass++;
        n_chk++; if (dbg_state !== IDLE) $display("FAIL rst_state: got %0d want %0d", dbg_state, IDLE); else n_pass++;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int k;
        logic [EW-1:0] e;
        ops[2][0] = 5'd3;
        ops[2][1] = 5'd7;
        tgt = 3;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0100;
        #1;
        n_chk++; if (bus.req_ready !== 4'b0100) $display("FAIL single_grant: got %b want 0100", bus.req_ready); else n_pass++;
        exp_q.push_back(model_rsp(2, tgt));
        model_ptr = 3;
        @(negedge clk); #1;
        n_chk++; if (mul_clr !== 1'b1 || mul_en !== 1'b0) $display("FAIL single_clr: got clr %b en %b want 1 0", mul_clr, mul_en); else n_pass++;
        n_chk++; if (mul_data_in !== {ops[2][1], ops[2][0]}) $display("FAIL single_operands: got %h want %h", mul_data_in, {ops[2][1], ops[2][0]}); else n_pass++;
        n_chk++; if (bus.req_ready !== '0) $display("FAIL single_busy_ready: got %b want 0", bus.req_ready); else n_pass++;
        bus.req_valid = '0;
        @(negedge clk); #1;
        n_chk++; if (mul_clr !== 1'b0 || mul_en !== 1'b1) $display("FAIL single_run: got clr %b en %b want 0 1", mul_clr, mul_en); else n_pass++;
        k = 0;
        while (!mul_done && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        n_chk++; if (k != tgt) $display("FAIL single_done_time: got %0d want %0d", k, tgt); else n_pass++;
        n_chk++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", bus.rsp_valid); else n_pass++;
        @(negedge clk); #1;
        e = exp_q.pop_front();
        n_chk++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", bus.rsp_valid); else n_pass++;
        n_chk++; if (bus.rsp_id !== e[EW-1 -: IW]) $display("FAIL single_id: got %0d want %0d", bus.rsp_id, e[EW-1 -: IW]); else n_pass++;
        n_chk++; if (bus.rsp_data !== e[EW-IW-1 -: PW]) $display("FAIL single_data: got %0d want %0d", bus.rsp_data, e[EW-IW-1 -: PW]); else n_pass++;
        n_chk++; if (bus.rsp_err !== 1'b0) $display("FAIL single_err: got %b want 0", bus.rsp_err); else n_pass++;
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        n_chk++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_valid_drop: got %b want 0", bus.rsp_valid); else n_pass++;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        gnt_log.delete();
        serve(4'b1001, 2, 1'b0, 0, 4, 1'b1);
        n_chk++; if (gnt_log.size() != 2 || gnt_log[0] != 3 || gnt_log[1] != 0) $display("FAIL wrap_order: got %p want 3 0", gnt_log); else n_pass++;
    endtask

    task automatic test_round_robin();
        int start;
        start = model_ptr;
        gnt_log.delete();
        serve(4'b1111, 5, 1'b1, 0, 6, 1'b1);
        n_chk++; if (gnt_log.size() != 5) $display("FAIL rr_count: got %0d want 5", gnt_log.size()); else n_pass++;
        for (int j = 0; j < gnt_log.size(); j++) begin
            n_chk++;
            if (gnt_log[j] != (start + j) % NR) $display("FAIL rr_order: got %0d want %0d", gnt_log[j], (start + j) % NR);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int k;
        int w;
        logic [EW-1:0] e;
        randomize_ops();
        tgt = $urandom_range(0, 5);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        #1;
        w = model_winner(bus.req_valid);
        n_chk++; if (bus.req_ready !== (NR'(1) << w)) $display("FAIL bp_grant: got %b want %b", bus.req_ready, NR'(1) << w); else n_pass++;
        e = model_rsp(w, tgt);
        model_ptr = (w + 1) % NR;
        @(negedge clk);
        bus.req_valid = 4'b0110;
        k = 0;
        while (!bus.rsp_valid && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        for (int c = 0; c < 10; c++) begin
            spur = 1'($urandom_range(0, 1));
            #1;
            n_chk++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", bus.rsp_valid); else n_pass++;
            n_chk++; if (bus.rsp_id !== e[EW-1 -: IW] || bus.rsp_data !== e[EW-IW-1 -: PW] || bus.rsp_err !== e[RLW])
                $display("FAIL bp_payload: got %0d/%0d/%b want %0d/%0d/%b", bus.rsp_id, bus.rsp_data, bus.rsp_err, e[EW-1 -: IW], e[EW-IW-1 -: PW], e[RLW]);
            else n_pass++;
            n_chk++; if (bus.req_ready !== '0) $display("FAIL bp_ready: got %b want 0", bus.req_ready); else n_pass++;
            @(negedge clk);
        end
        spur = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        w = model_winner(bus.req_valid);
        n_chk++; if (bus.rsp_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b want 0", bus.rsp_valid); else n_pass++;
        n_chk++; if (bus.req_ready !== (NR'(1) << w)) $display("FAIL bp_regrant: got %b want %b", bus.req_ready, NR'(1) << w); else n_pass++;
        bus.req_valid = '0;
        #1;
        n_chk++; if (bus.req_ready !== '0) $display("FAIL bp_withdraw: got %b want 0", bus.req_ready); else n_pass++;
        @(negedge clk); #1;
        n_chk++; if (dbg_state !== IDLE) $display("FAIL bp_stay_idle: got %0d want %0d", dbg_state, IDLE); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_watchdog();
        serve(4'b1000, 1, 1'b0, TIMEOUT + 100, TIMEOUT + 100, 1'b1);
        serve(4'b0100, 1, 1'b1, TIMEOUT - 1, TIMEOUT - 1, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        int w;
        randomize_ops();
        tgt = TIMEOUT + 100;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0001;
        #1;
        w = model_winner(bus.req_valid);
        n_chk++; if (bus.req_ready !== (NR'(1) << w)) $display("FAIL mid_grant: got %b want %b", bus.req_ready, NR'(1) << w); else n_pass++;
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk); #1;
        n_chk++; if (mul_en !== 1'b1) $display("FAIL mid_in_run: got %b want 1", mul_en); else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++; if (mul_en !== 1'b0 || mul_clr !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== '0)
            $display("FAIL mid_ctl_zero: got en %b clr %b v %b rdy %b want all 0", mul_en, mul_clr, bus.rsp_valid, bus.req_ready);
        else n_pass++;
        n_chk++; if (mul_data_in !== '0 || bus.rsp_id !== '0 || bus.rsp_data !== '0 || bus.rsp_err !== 1'b0)
            $display("FAIL mid_data_zero: got %h/%0d/%0d/%b want all 0", mul_data_in, bus.rsp_id, bus.rsp_data, bus.rsp_err);
        else n_pass++;
        model_ptr = 0;
        busy = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        tgt = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            n_chk++; if (bus.rsp_valid !== 1'b0) $display("FAIL mid_no_rsp: got %b want 0", bus.rsp_valid); else n_pass++;
            @(negedge clk);
        end
        gnt_log.delete();
        serve(4'b1111, 1, 1'b0, 0, 3, 1'b1);
        n_chk++; if (gnt_log.size() != 1 || gnt_log[0] != 0) $display("FAIL mid_ptr_reset: got %p want 0", gnt_log); else n_pass++;
        ops[1][0] = 5'd31;
        ops[1][1] = 5'd31;
        serve(4'b0010, 1, 1'b0, 2, 2, 1'b0);
        n_chk++; if (last_rsp_data !== PW'(961)) $display("FAIL mid_961: got %0d want 961", last_rsp_data); else n_pass++;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_watchdog();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no completion want completion by 2ms");
        $fatal(1, "simulation time limit");
    end
endmodule

// File: doc/ms_es_mul_sched.md
Name: ms_es_mul_sched

Overview:
- Scheduler that shares one ms_es_naive_by2_mul instance among NUM_REQ requesters.
- Round-robin arbitration between requesters.
- For each granted job: latches the operands, clears the multiplier, runs it until done or a watchdog expires, then returns the tagged product over a valid/ready response port.
- Sits between the requester fabric and the core wrapper of the multiplier.

Parameters:
- DATA_WIDTH, 5, width of each operand.
- NUM_INPUTS, 2, operands per job; the product is NUM_INPUTS*DATA_WIDTH bits.
- NUM_REQ, 4, number of requesters (min 2).
- TIMEOUT, 2**(NUM_INPUTS*DATA_WIDTH)+8, maximum RUN cycles before the job is aborted.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester job valid
- req_data  in  NUM_REQ*NUM_INPUTS*DATA_WIDTH  flattened operands; requester r occupies slice r, operand i sits at offset i*DATA_WIDTH within it
- req_ready  out  NUM_REQ  one-hot grant/accept
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accepted
- rsp_id  out  $clog2(NUM_REQ)  requester index of the result
- rsp_data  out  NUM_INPUTS*DATA_WIDTH  product
- rsp_err  out  1  job aborted by watchdog
- mul_clr  out  1  one-cycle active-high clear to the multiplier
- mul_en  out  1  multiplier enable
- mul_data_in  out  [DATA_WIDTH-1:0] x NUM_INPUTS  operands to the multiplier
- mul_data_out  in  NUM_INPUTS*DATA_WIDTH  multiplier result
- mul_done  in  1  multiplier op_finished

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, rr_ptr=0, cycle counter=0.
  - All outputs 0: req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, mul_clr, mul_en, mul_data_in.
- Reset mid-job discards the job; no response is produced.
- States: IDLE -> CLR -> RUN -> RESP -> IDLE.
- IDLE:
  - req_ready is driven combinationally, one-hot, for the first valid requester searching upward from rr_ptr and wrapping at NUM_REQ.
  - No valid requester: req_ready=0.
  - On handshake: latch operands into mul_data_in and the index into rsp_id, set rr_ptr=(winner+1) mod NUM_REQ, go to CLR.
- req_ready is 0 in every state except IDLE.
- CLR: mul_clr=1 and mul_en=0 for exactly one cycle; counter cleared; go to RUN.
- RUN:
  - mul_en=1; counter increments each cycle.
  - mul_data_in holds the latched operands, stable for the whole job.
  - mul_done=1: capture mul_data_out into rsp_data, rsp_err=0, go to RESP.
  - counter==TIMEOUT-1 without done: rsp_data=0, rsp_err=1, go to RESP.
  - done and timeout in the same cycle: done wins, rsp_err=0.
- RESP:
  - mul_en=0; rsp_valid=1.
  - rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1, then go to IDLE.
  - rsp_valid is registered and drops the cycle after the handshake.
- Latency: request handshake at cycle T, mul_clr at T+1, mul_en from T+2. If mul_done is seen at T+2+k, rsp_valid rises at T+3+k.
- Back-to-back throughput: next grant no earlier than the cycle after the response handshake.
- mul_done outside RUN is ignored.
- req_valid may drop without a handshake; no state change results.
- Counter width: $clog2(TIMEOUT+1); the counter saturates and never wraps.

Decomposition:
- Package ms_es_sched_pkg holds:
  - state enum sched_state_t {IDLE, CLR, RUN, RESP};
  - typedef operand_t = logic [DATA_WIDTH-1:0];
  - default TIMEOUT function of DATA_WIDTH and NUM_INPUTS.
- One sub-module, rr_arbiter:
  - parameter N;
  - inputs: req, ptr, en;
  - outputs: one-hot grant, grant_idx.
- The scheduler FSM and the watchdog stay in ms_es_mul_sched.

Test Plan (DATA_WIDTH=5, NUM_INPUTS=2, NUM_REQ=4, real multiplier through core):
- Single job: requester 2 sends {3,7} -> one mul_clr pulse, then mul_en. Response has rsp_id=2, rsp_data=21, rsp_err=0; rsp_valid rises one cycle after mul_done.
- Round-robin fairness: all four req_valid held high with distinct operands -> grants in order 0,1,2,3,0; each rsp_id matches its operands' product; req_ready stays one-hot.
- Pointer wrap: rr_ptr=3 after serving 2; requesters 0 and 3 valid -> 3 granted, then 0.
- Backpressure: rsp_ready held low for 10 cycles -> rsp_valid, rsp_id and rsp_data stable, req_ready=0, no new grant; grant occurs the cycle after rsp_ready rises.
- Watchdog: stub multiplier never asserts done -> after TIMEOUT RUN cycles rsp_err=1, rsp_data=0, then IDLE. With done forced on the final timeout cycle -> rsp_err=0 and the product is returned.
- Reset mid-RUN: rst low for 1 cycle during RUN -> all outputs 0 immediately, no response produced, rr_ptr=0; the next request from 1 with {31,31} returns 961.
